// File: rtl/conv_fill_sched.sv
// Job-level fill scheduler for the conv-unit array: round-robin block reads from the shared
// DDR channel into per-unit weight/feature buffers, array advance gating and job completion.
module conv_fill_sched #(
    parameter int N_CONV_UNIT     = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int UNIT_BURSTS_WEI = 32,
    parameter int UNIT_BURSTS_FTM = 1024,
    parameter int B_BLK           = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [B_BLK-1:0]                 cfg_n_wei_blk,
    input  logic [B_BLK-1:0]                 cfg_n_ftm_blk,
    output logic                             busy,
    output logic                             done,
    input  logic [N_CONV_UNIT-1:0]           wb_full,
    input  logic [N_CONV_UNIT-1:0]           fb_full,
    input  logic [N_CONV_UNIT-1:0]           wb_suff,
    input  logic [N_CONV_UNIT-1:0]           fb_suff,
    input  logic                             compute_done,
    output logic                             wb_clr,
    output logic                             fb_clr,
    output logic [N_CONV_UNIT-1:0]           wb_we,
    output logic [N_CONV_UNIT-1:0]           fb_we,
    output logic [DATA_WIDTH-1:0]            di,
    output logic                             rd_req,
    output logic [$clog2(2*N_CONV_UNIT)-1:0] rd_sel,
    output logic [15:0]                      rd_beats,
    input  logic                             rd_ack,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    input  logic                             rd_valid,
    output logic                             rd_ready,
    output logic                             pipe_en
);

    localparam int N_REQ = 2 * N_CONV_UNIT;
    localparam int SEL_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(UNIT_BURSTS_FTM) + 1;
    localparam logic [15:0] BEATS_WEI = 16'(UNIT_BURSTS_WEI);
    localparam logic [15:0] BEATS_FTM = 16'(UNIT_BURSTS_FTM);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_STREAM, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [B_BLK-1:0]      r_rem [N_REQ];
    logic [SEL_W-1:0]      r_ptr;
    logic [SEL_W-1:0]      r_sel;
    logic [15:0]           r_beats;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_clr;
    logic                  r_pipe_en;
    logic [N_REQ-1:0]      r_we_p1;
    logic [DATA_WIDTH-1:0] r_di_p1;

    logic [N_REQ-1:0]      w_full;
    logic [N_REQ-1:0]      w_elig;
    logic                  w_any_rem;
    logic                  w_any_elig;
    logic [SEL_W-1:0]      w_pick;
    logic [SEL_W:0]        w_j;
    logic                  w_vld_p0;
    logic                  w_last;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [SEL_W-1:0]      w_sel_inc;

    // Requester k < N is weight unit k, k >= N is feature unit k-N.
    assign w_full = {fb_full, wb_full};

    always_comb begin
        w_elig    = '0;
        w_any_rem = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_elig[k] = (r_rem[k] != '0) && !w_full[k];
            w_any_rem = w_any_rem | (r_rem[k] != '0);
        end
    end

    // Rotating priority: first eligible requester at or after r_ptr, wrapping at N_REQ.
    always_comb begin
        w_pick     = '0;
        w_any_elig = 1'b0;
        w_j        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_j = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (w_j >= (SEL_W+1)'(N_REQ)) begin
                w_j = w_j - (SEL_W+1)'(N_REQ);
            end
            if (!w_any_elig && w_elig[w_j[SEL_W-1:0]]) begin
                w_any_elig = 1'b1;
                w_pick     = w_j[SEL_W-1:0];
            end
        end
    end

    assign w_vld_p0  = (r_state == S_STREAM) && rd_valid;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = w_vld_p0 && (w_cnt_inc == r_beats[CNT_W-1:0]);
    assign w_sel_inc = (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ARB;
            S_ARB: begin
                if (w_any_elig) w_state_nxt = S_REQ;
                else if (!w_any_rem) w_state_nxt = S_DRAIN;
            end
            S_REQ:    if (rd_ack) w_state_nxt = S_STREAM;
            S_STREAM: if (w_last) w_state_nxt = S_ARB;
            S_DRAIN:  if (compute_done) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_beats   <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_clr     <= 1'b0;
            r_pipe_en <= 1'b0;
            r_we_p1   <= '0;
            r_di_p1   <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                r_rem[k] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_clr     <= (r_state == S_IDLE) && start;
            r_done    <= (r_state == S_DRAIN) && compute_done;
            r_pipe_en <= r_busy && (&wb_suff) && (&fb_suff);
            // p0 -> p1: accepted beat becomes buffer write data and one-hot enable
            r_we_p1   <= w_vld_p0 ? (N_REQ'(1) << r_sel) : '0;
            if (w_vld_p0) begin
                r_di_p1 <= rd_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        for (int k = 0; k < N_REQ; k++) begin
                            r_rem[k] <= (k < N_CONV_UNIT) ? cfg_n_wei_blk : cfg_n_ftm_blk;
                        end
                    end
                end
                S_ARB: begin
                    if (w_any_elig) begin
                        r_sel   <= w_pick;
                        r_beats <= (w_pick < SEL_W'(N_CONV_UNIT)) ? BEATS_WEI : BEATS_FTM;
                    end
                end
                S_REQ: begin
                    r_cnt <= '0;
                end
                S_STREAM: begin
                    if (w_vld_p0) begin
                        r_cnt <= w_cnt_inc;
                        if (w_last) begin
                            r_rem[r_sel] <= r_rem[r_sel] - 1'b1;
                            r_ptr        <= w_sel_inc;
                        end
                    end
                end
                S_DRAIN: begin
                    if (compute_done) begin
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign wb_clr   = r_clr;
    assign fb_clr   = r_clr;
    assign wb_we    = r_we_p1[N_CONV_UNIT-1:0];
    assign fb_we    = r_we_p1[N_REQ-1:N_CONV_UNIT];
    assign di       = r_di_p1;
    assign rd_req   = (r_state == S_REQ);
    assign rd_sel   = r_sel;
    assign rd_beats = r_beats;
    assign rd_ready = (r_state == S_STREAM);
    assign pipe_en  = r_pipe_en;

endmodule
